ps2_scan_ctrl: RTL and testbench
================================

Name: ps2_scan_ctrl

Overview:
- Sequencer between the ps2_keyboard receiver FIFO and the display/counter logic.
- Pops bytes using the ready/nextdata_n handshake and parses E0 (extended) and F0 (break) prefixes.
- Emits one decoded key event per complete scancode sequence.
- Keeps a fresh-press counter and the held-key state, replacing ad-hoc state machines clocked on ps2_clk with one clk-domain controller.

Parameters:
- TIMEOUT_CYC, 1000000: clk cycles a pending prefix may wait for its next byte before it is discarded.
- CNT_W, 8: width of press_count.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  asynchronous reset, active-high.
- ps2_data_in  input  8  FIFO head byte from ps2_keyboard.
- ps2_ready  input  1  FIFO non-empty.
- ps2_overflow  input  1  FIFO overflow flag.
- nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
- key_valid  output  1  one-cycle event strobe.
- key_code  output  8  scancode of the last event.
- key_ext  output  1  last event was E0-prefixed.
- key_break  output  1  last event was a release (F0).
- key_down  output  1  level: a key is currently held.
- press_count  output  CNT_W  count of fresh presses; wraps.
- err  output  1  sticky overflow seen.

Behaviour:
- Reset values (clr=1, async): nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_break=0, key_down=0, press_count=0, err=0, pending flags cleared, state=IDLE, timeout counter 0.
- States: IDLE, POP, SETTLE, PARSE.
- IDLE: when ps2_ready=1, capture ps2_data_in into byte_r and go to POP.
- POP: nextdata_n=0 for exactly this one cycle; go to SETTLE.
- SETTLE: nextdata_n=1; one dead cycle so ps2_ready reflects the new FIFO head; go to PARSE.
- PARSE handles byte_r, then returns to IDLE:
  - E0: set ext_p.
  - F0: set brk_p.
  - Any other byte completes an event: key_code=byte_r, key_ext=ext_p, key_break=brk_p, key_valid=1 for one cycle (subject to the optional filter); clear ext_p and brk_p.
- Minimum spacing is 4 clk per byte (IDLE→POP→SETTLE→PARSE); back-to-back FIFO bytes are consumed without loss.
- Held-key tracking, with registers held_code/held_ext:
  - Make whose {ext,code} differs from held, or arrives while key_down=0: press_count+1 (modulo 2^CNT_W), key_down=1, held updated.
  - Make equal to held while key_down=1 is typematic repeat: no count.
  - Break matching held: key_down=0. Break not matching held: event emitted, key_down unchanged.
- Prefix timeout:
  - Counter runs while ext_p or brk_p is set and state=IDLE.
  - Reaching TIMEOUT_CYC-1 clears both flags and the counter; no event.
  - Counter resets on every byte capture.
- ps2_overflow=1 on any cycle: err=1 (sticky until clr), and ext_p/brk_p are cleared on that cycle.
  - If it coincides with PARSE of a prefix byte, the clear wins.
  - If it coincides with PARSE of a complete byte, the event is still emitted using the flags as they were before the clear.
- clr mid-sequence (including during POP): nextdata_n returns to 1 immediately; the partially parsed sequence is lost.
- ps2_ready falling while in POP/SETTLE: no effect; the captured byte is still parsed.

Optional Feature:
- Macro TYPEMATIC_FILTER_EN.
- Defined: a typematic repeat make does not assert key_valid; key_code/key_ext/key_break hold their previous values.
- Undefined: every completed make/break asserts key_valid, including repeats.
- press_count and key_down behave identically in both builds.

Test Plan:
- Single key: FIFO bytes 1C, F0, 1C → two key_valid pulses:
  - first: code=1C, break=0
  - second: code=1C, break=1
  - Final state press_count=1, key_down=0; nextdata_n low exactly 3 single cycles.
- Extended key: E0, 75, E0, F0, 75 → events {ext=1, code=75, break=0} and {ext=1, code=75, break=1}; press_count=1.
- Typematic: 1C, 1C, 1C, F0, 1C:
  - with TYPEMATIC_FILTER_EN: 2 key_valid pulses
  - without: 4 pulses
  - both builds: press_count=1.
- Prefix timeout (TIMEOUT_CYC=16): F0, idle 20 cycles, then 1C → event break=0, press_count=1.
- Wrap and overflow (CNT_W=8): 256 distinct alternating make/break pairs → press_count wraps to 0. ps2_overflow pulse after F0 → err=1, and the next 1C reports break=0.
- Async clr asserted during POP → all outputs at reset values before the next clk edge; after release, the next FIFO byte is parsed normally.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: clk-domain sequencer between the ps2_keyboard receiver FIFO and the
// display/counter logic. Pops FIFO bytes with a ready/nextdata_n handshake, parses the
// E0 (extended) and F0 (break) prefixes, emits one key event per complete scancode
// sequence, and tracks the held key plus a wrapping fresh-press counter.
//
// Optional build feature: define TYPEMATIC_FILTER_EN to suppress key_valid for
// typematic repeat makes (key_code/key_ext/key_break then hold their previous values).
// press_count and key_down behave the same in both builds.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   clr          in   asynchronous active-high reset
//   ps2_data_in  in   [7:0] FIFO head byte
//   ps2_ready    in   FIFO non-empty
//   ps2_overflow in   FIFO overflow flag
//   nextdata_n   out  active-low pop strobe (one cycle per byte)
//   key_valid    out  one-cycle event strobe
//   key_code     out  [7:0] scancode of the last event
//   key_ext      out  last event was E0-prefixed
//   key_break    out  last event was a release
//   key_down     out  a key is currently held
//   press_count  out  [CNT_W-1:0] fresh-press count, wraps
//   err          out  sticky overflow seen
module ps2_scan_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       ps2_data_in,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] ByteExt = 8'hE0;
  localparam logic [7:0] ByteBrk = 8'hF0;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPop    = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StParse  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_p_q, ext_p_d;
  logic             brk_p_q, brk_p_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic             valid_q, valid_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             down_q, down_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic is_make;
  logic is_match;
  logic is_repeat;
  logic emit;

  // Event classification for the byte currently being parsed; prefix flags are the
  // values accumulated before this byte.
  always_comb begin
    is_make   = ~brk_p_q;
    is_match  = (ext_p_q == held_ext_q) && (byte_q == held_code_q);
    is_repeat = is_make && down_q && is_match;
`ifdef TYPEMATIC_FILTER_EN
    emit      = ~is_repeat;
`else
    emit      = 1'b1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    ext_p_d     = ext_p_q;
    brk_p_d     = brk_p_q;
    to_cnt_d    = to_cnt_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    valid_d     = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    down_d      = down_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (ps2_ready) begin
          byte_d   = ps2_data_in;
          to_cnt_d = '0;
          state_d  = StPop;
        end else if (ext_p_q || brk_p_q) begin
          // A prefix left waiting too long is stale; drop it silently.
          if (to_cnt_q == ToLast) begin
            ext_p_d  = 1'b0;
            brk_p_d  = 1'b0;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      StPop:    state_d = StSettle;
      // Dead cycle so ps2_ready reflects the new FIFO head before IDLE samples it.
      StSettle: state_d = StParse;
      StParse: begin
        state_d = StIdle;
        if (byte_q == ByteExt) begin
          ext_p_d = 1'b1;
        end else if (byte_q == ByteBrk) begin
          brk_p_d = 1'b1;
        end else begin
          if (is_make && !is_repeat) begin
            cnt_d       = cnt_q + CNT_W'(1);
            down_d      = 1'b1;
            held_code_d = byte_q;
            held_ext_d  = ext_p_q;
          end else if (!is_make && is_match) begin
            down_d = 1'b0;
          end
          if (emit) begin
            valid_d = 1'b1;
            code_d  = byte_q;
            ext_d   = ext_p_q;
            brk_d   = brk_p_q;
          end
          ext_p_d = 1'b0;
          brk_p_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Overflow discards any pending prefix; an event parsed this cycle already used
    // the pre-clear flags above.
    if (ps2_overflow) begin
      err_d   = 1'b1;
      ext_p_d = 1'b0;
      brk_p_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StIdle;
      byte_q      <= 8'h00;
      ext_p_q     <= 1'b0;
      brk_p_q     <= 1'b0;
      to_cnt_q    <= '0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      down_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ext_p_q     <= ext_p_d;
      brk_p_q     <= brk_p_d;
      to_cnt_q    <= to_cnt_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      down_q      <= down_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Decoded from state so an async clear during POP releases the strobe at once.
  assign nextdata_n  = (state_q != StPop);
  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_ext     = ext_q;
  assign key_break   = brk_q;
  assign key_down    = down_q;
  assign press_count = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a queue-based FIFO model feeds the DUT, a
// behavioural key model predicts events into a queue, and a monitor pops and compares
// on every key_valid strobe.
module tb_ps2_scan_ctrl;

  localparam int unsigned TO = 16;
`ifdef TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] ps2_data_in = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       nextdata_n, key_valid, key_ext, key_break, key_down, err;
  logic [7:0] key_code, press_count;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .clr          (clr),
    .ps2_data_in  (ps2_data_in),
    .ps2_ready    (ps2_ready),
    .ps2_overflow (ps2_overflow),
    .nextdata_n   (nextdata_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_break    (key_break),
    .key_down     (key_down),
    .press_count  (press_count),
    .err          (err)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       down;
    logic [7:0] cnt;
  } ev_t;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  int n_vec = 0, n_fail = 0, n_ev = 0, n_pops = 0, n_pushes = 0, n_wide = 0;
  logic nd_prev = 1'b1;

  // Key model state
  bit       m_ext, m_brk, m_down, m_held_ext, m_err;
  bit [7:0] m_held_code;
  int       m_cnt;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic void drive_fifo();
    ps2_ready   = (fifo.size() != 0);
    ps2_data_in = ps2_ready ? fifo[0] : 8'h00;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_down = 0; m_held_ext = 0; m_held_code = 8'h00;
    m_cnt = 0; m_err = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    ev_t e;
    bit  make, match, rep;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      make  = !m_brk;
      match = (m_ext == m_held_ext) && (b == m_held_code);
      rep   = make && m_down && match;
      if (make && !rep) begin
        m_cnt = (m_cnt + 1) % 256;
        m_down = 1;
        m_held_code = b;
        m_held_ext = m_ext;
      end else if (!make && match) begin
        m_down = 0;
      end
      if (!(FILT && rep)) begin
        e.code = b; e.ext = m_ext; e.brk = m_brk; e.down = m_down; e.cnt = m_cnt[7:0];
        exp_q.push_back(e);
      end
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  // FIFO pop side and strobe-width tracking
  always @(negedge clk) begin
    if (!clr && !nextdata_n) begin
      n_pops++;
      if (!nd_prev) n_wide++;
      if (fifo.size() != 0) void'(fifo.pop_front());
      drive_fifo();
    end
    nd_prev = nextdata_n;
  end

  // Monitor
  always @(negedge clk) begin
    if (!clr && key_valid) begin
      n_ev++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", {23'd0, key_ext, key_break, key_code}, 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_code", key_code, e.code);
        check("ev_ext", key_ext, e.ext);
        check("ev_break", key_break, e.brk);
        check("ev_down", key_down, e.down);
        check("ev_count", press_count, e.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo.push_back(b);
    drive_fifo();
    n_pushes++;
  endtask

  task automatic push(input logic [7:0] b);
    push_raw(b);
    model_byte(b);
  endtask

  task automatic drain();
    int k = 0;
    while (fifo.size() != 0 && k < 400) begin
      tick(1);
      k++;
    end
    check("drain_empty", fifo.size(), 0);
    tick(5);
  endtask

  task automatic gap_long();
    tick(40);
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic pulse_ovf();
    ps2_overflow = 1'b1;
    tick(1);
    ps2_overflow = 1'b0;
    m_err = 1;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_down"}, key_down, m_down);
    check({tag, "_count"}, press_count, m_cnt[7:0]);
    check({tag, "_err"}, err, m_err);
    check({tag, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nextdata_n"}, nextdata_n, 1);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_ext"}, key_ext, 0);
    check({tag, "_break"}, key_break, 0);
    check({tag, "_down"}, key_down, 0);
    check({tag, "_count"}, press_count, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int p0, e0;
    logic [7:0] c0, d;
    logic [7:0] codes[6];
    bit got_pop;
    codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h75;
    codes[3] = 8'h29; codes[4] = 8'h5A; codes[5] = 8'h00;
    model_reset();

    #1 check_reset_outputs("reset");
    tick(2);
    check_reset_outputs("reset_held");
    clr = 1'b0;
    tick(2);

    // Single key make/break
    p0 = n_pops; e0 = n_ev;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check_state("single");
    check("single_pops", n_pops - p0, 3);
    check("single_events", n_ev - e0, 2);
    check("single_count", press_count, 1);
    check("single_down", key_down, 0);
    check("strobe_width", n_wide, 0);

    // Extended key
    c0 = press_count; e0 = n_ev;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check_state("ext");
    d = press_count - c0;
    check("ext_count_delta", d, 1);
    check("ext_events", n_ev - e0, 2);

    // Typematic repeats
    c0 = press_count; e0 = n_ev;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check_state("typematic");
    d = press_count - c0;
    check("typematic_count_delta", d, 1);
    check("typematic_events", n_ev - e0, FILT ? 2 : 4);

    // Prefix timeout
    c0 = press_count; e0 = n_ev;
    push(8'hF0);
    drain();
    gap_long();
    push(8'h1C);
    drain();
    check_state("timeout");
    d = press_count - c0;
    check("timeout_count_delta", d, 1);
    check("timeout_events", n_ev - e0, 1);
    check("timeout_break", key_break, 0);

    // Overflow discards the pending break prefix
    push(8'hF0); push(8'h1C);
    drain();
    push(8'hF0);
    drain();
    pulse_ovf();
    push(8'h1C);
    drain();
    check_state("ovf");
    check("ovf_err", err, 1);
    check("ovf_break", key_break, 0);
    check("ovf_down", key_down, 1);
    push(8'hF0); push(8'h1C);
    drain();

    // 256 distinct make/break pairs wrap the 8-bit counter
    c0 = press_count; e0 = n_ev;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] code;
      code = {1'b0, 7'(i)} + 8'd1;
      if (i >= 128) push(8'hE0);
      push(code);
      if (i >= 128) push(8'hE0);
      push(8'hF0);
      push(code);
      drain();
    end
    check_state("wrap");
    check("wrap_count_same", press_count, c0);
    check("wrap_events", n_ev - e0, 512);

    // Async clear while the pop strobe is active
    push_raw(8'h1C);
    got_pop = 0;
    for (int k = 0; k < 20 && !got_pop; k++) begin
      @(posedge clk);
      #1;
      if (!nextdata_n) got_pop = 1;
    end
    check("clr_saw_pop", got_pop, 1);
    clr = 1'b1;
    #1 check_reset_outputs("clr_pop");
    model_reset();
    tick(2);
    clr = 1'b0;
    model_byte(8'h1C);
    drain();
    check_state("after_clr");
    check("after_clr_code", key_code, 8'h1C);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int burst, g;
      burst = $urandom_range(1, 4);
      for (int j = 0; j < burst; j++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) push(8'hE0);
        else if (r < 4) push(8'hF0);
        else push(codes[$urandom_range(0, 5)]);
      end
      drain();
      check_state("rand");
      g = $urandom_range(0, 9);
      if (g == 0) gap_long();
      else if (g == 1) pulse_ovf();
      else tick($urandom_range(0, 3));
    end
    drain();

    check("pops_eq_pushes", n_pops, n_pushes);
    check("strobe_width_final", n_wide, 0);
    check("events_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
